// File: rtl/change_dispenser.sv
// ----------------------------------------------------------------------------
// change_dispenser
//
// Sits downstream of the vending control FSM. Every time the FSM enters its
// RETURN_CHANGE state, this block captures the inserted sum and the item
// price. If the customer paid enough, it pulses an item release. It then pays
// back the change (or the full sum when underpaid) one coin at a time, always
// choosing the largest coin that still fits. Coins go to the hopper over a
// valid/ready link. Any remainder smaller than the smallest coin is reported
// as residue, and completion is signalled by a one-cycle done pulse.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   fsm_state   in   [2:0]   control FSM state
//   sum_money   in   [W-1:0] total inserted money
//   price       in   [W-1:0] price of the selected item
//   item_in     in   [1:0]   selected item index
//   coin_ready  in   hopper accepts a coin this cycle
//   coin_valid  out  coin request valid
//   coin_deno   out  [1:0]   coin code: 01 LO, 10 MID, 11 HI (00 when idle)
//   item_valid  out  one-cycle item-release pulse
//   item_id     out  [1:0]   item to release, qualified by item_valid
//   busy        out  transaction in progress
//   done        out  one-cycle completion pulse
//   residue     out  [W-1:0] unpaid remainder of the last transaction
// ----------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned    W         = 5,
    parameter logic [W-1:0]   VAL_HI    = W'(20),
    parameter logic [W-1:0]   VAL_MID   = W'(10),
    parameter logic [W-1:0]   VAL_LO    = W'(5),
    parameter logic [2:0]     ST_RETURN = 3'd5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   fsm_state,
    input  logic [W-1:0] sum_money,
    input  logic [W-1:0] price,
    input  logic [1:0]   item_in,
    input  logic         coin_ready,
    output logic         coin_valid,
    output logic [1:0]   coin_deno,
    output logic         item_valid,
    output logic [1:0]   item_id,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] residue
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_DISPENSE,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   prev_state_q;
    logic [W-1:0] remain_q, remain_d;
    logic [1:0]   item_q, item_d;
    logic         paid_q, paid_d;
    logic [W-1:0] residue_q, residue_d;

    logic         entry;
    logic         paid_now;
    logic [1:0]   pick_code;
    logic [W-1:0] pick_value;

    // A transaction starts only on the rising edge into RETURN_CHANGE.
    // An FSM that stays parked in that state therefore starts just one transaction.
    assign entry    = (fsm_state == ST_RETURN) && (prev_state_q != ST_RETURN);
    assign paid_now = (sum_money >= price);

    // Greedy coin choice from the registered remainder. Because it depends only
    // on state, the request stays stable until the hopper takes the coin.
    always_comb begin
        pick_code  = 2'b00;
        pick_value = '0;
        if (remain_q >= VAL_HI) begin
            pick_code  = 2'b11;
            pick_value = VAL_HI;
        end else if (remain_q >= VAL_MID) begin
            pick_code  = 2'b10;
            pick_value = VAL_MID;
        end else if (remain_q >= VAL_LO) begin
            pick_code  = 2'b01;
            pick_value = VAL_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prev_state_q <= 3'd0;
            remain_q     <= '0;
            item_q       <= 2'b00;
            paid_q       <= 1'b0;
            residue_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_state_q <= fsm_state;
            remain_q     <= remain_d;
            item_q       <= item_d;
            paid_q       <= paid_d;
            residue_q    <= residue_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        item_d     = item_q;
        paid_d     = paid_q;
        residue_d  = residue_q;
        coin_valid = 1'b0;
        coin_deno  = 2'b00;
        item_valid = 1'b0;
        item_id    = 2'b00;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (entry) begin
                    // Subtract only when paid, so an underpaid sum never wraps
                    // and is refunded in full instead.
                    paid_d   = paid_now;
                    remain_d = paid_now ? (sum_money - price) : sum_money;
                    item_d   = item_in;
                    state_d  = S_VEND;
                end
            end

            S_VEND: begin
                busy       = 1'b1;
                item_valid = paid_q;
                item_id    = paid_q ? item_q : 2'b00;
                // With no payable change, go straight to DONE so that done
                // appears two cycles after the entry edge.
                state_d    = (remain_q >= VAL_LO) ? S_DISPENSE : S_DONE;
            end

            S_DISPENSE: begin
                busy = 1'b1;
                if (remain_q >= VAL_LO) begin
                    coin_valid = 1'b1;
                    coin_deno  = pick_code;
                    if (coin_ready) begin
                        remain_d = remain_q - pick_value;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                residue_d = remain_q;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign residue = residue_q;

endmodule
